// File: rtl/image_lcd_blit_pkg.sv
// Shared constants, LCD command codes, FSM state type and the RGB888 -> RGB565 packer
// used by the image-to-lcd blitter.
package image_lcd_blit_pkg;

    localparam int WIDTH     = 10;
    localparam int HEIGHT    = 10;
    localparam int WIDTH_W   = 4;
    localparam int HEIGHT_W  = 4;
    localparam int C0_W      = 8;
    localparam int C1_W      = 8;
    localparam int C2_W      = 8;
    localparam int DATA_W    = C0_W + C1_W + C2_W;
    localparam int COORD_W   = 9;
    localparam int CMD_W     = 3;
    localparam int PIXEL_W   = 16;
    localparam int PANEL_W   = 480;
    localparam int PANEL_H   = 320;
    localparam int SCALE_W   = 3;
    localparam int EXT_W     = COORD_W + 4;

    localparam logic [CMD_W-1:0] LCD_COMMAND_NONE       = 3'd0;
    localparam logic [CMD_W-1:0] LCD_COMMAND_WRITE_RECT = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_STREAM,
        ST_DONE
    } blit_state_e;

    // Keeps the top bits of each component: R[7:3], G[7:2], B[7:3].
    function automatic logic [PIXEL_W-1:0] rgb888_to_565(input logic [DATA_W-1:0] c);
        return {c[23:19], c[15:10], c[7:3]};
    endfunction

endpackage

// File: rtl/image_lcd_blit_if.sv
// LCD-side bundle of the blitter: command/rect setup plus the valid/ready pixel stream.
interface image_lcd_blit_if;
    import image_lcd_blit_pkg::*;

    logic [CMD_W-1:0]   command;
    logic               lcd_ready;
    logic [COORD_W-1:0] rect_x0;
    logic [COORD_W-1:0] rect_x1;
    logic [COORD_W-1:0] rect_y0;
    logic [COORD_W-1:0] rect_y1;
    logic [PIXEL_W-1:0] rect_pixel_write;
    logic               rect_pixel_write_valid;
    logic               rect_pixel_write_ready;

    modport master (
        output command, rect_x0, rect_x1, rect_y0, rect_y1,
        output rect_pixel_write, rect_pixel_write_valid,
        input  lcd_ready, rect_pixel_write_ready
    );

    modport slave (
        input  command, rect_x0, rect_x1, rect_y0, rect_y1,
        input  rect_pixel_write, rect_pixel_write_valid,
        output lcd_ready, rect_pixel_write_ready
    );

endinterface

// File: rtl/image_lcd_pixel_fifo.sv
// Two-entry skid FIFO for RGB565 pixels; the writer only pushes when it has reserved room.
module image_lcd_pixel_fifo
    import image_lcd_blit_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid_i,
    input  logic [PIXEL_W-1:0] in_data_i,
    input  logic               out_ready_i,
    output logic               out_valid_o,
    output logic [PIXEL_W-1:0] out_data_o,
    output logic [1:0]         count_o
);

    logic [PIXEL_W-1:0] head_q;
    logic [PIXEL_W-1:0] tail_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic               pop;

    assign pop     = out_ready_i && (count_q != 2'd0);
    assign count_d = count_q + 2'(in_valid_i) - 2'(pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload registers carry no reset; count_q alone decides what is valid.
    always_ff @(posedge clock) begin
        if (pop) begin
            if (count_q == 2'd2) begin
                head_q <= tail_q;
                if (in_valid_i) tail_q <= in_data_i;
            end else if (in_valid_i) begin
                head_q <= in_data_i;
            end
        end else if (in_valid_i) begin
            if (count_q == 2'd0) head_q <= in_data_i;
            else                 tail_q <= in_data_i;
        end
    end

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign count_o     = count_q;

endmodule

// File: rtl/image_lcd_blit.sv
// Blits the stored RGB888 image into the lcd WRITE_RECT stream as RGB565, replicating each
// source pixel scale x scale times at a chosen panel origin.
module image_lcd_blit
    import image_lcd_blit_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [COORD_W-1:0]  origin_x,
    input  logic [COORD_W-1:0]  origin_y,
    input  logic [SCALE_W-1:0]  scale,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WIDTH_W-1:0]  buffer_out_x,
    output logic [HEIGHT_W-1:0] buffer_out_y,
    input  logic [DATA_W-1:0]   buffer_out_data,
    image_lcd_blit_if.master    lcd
);

    blit_state_e        state_q, state_d;
    logic [SCALE_W-1:0] s_in, smax_q, sx_q, sy_q;
    logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [WIDTH_W-1:0] ax_q;
    logic [HEIGHT_W-1:0] ay_q;
    logic               pend_q, reads_done_q, rej_q;
    logic [EXT_W-1:0]   x1_ext, y1_ext;
    logic               reject, accept_start, issue, pop, last_read, last_accept;
    logic [1:0]         fifo_count;
    logic [2:0]         occupancy;
    logic [PIXEL_W-1:0] pixel_in;

    assign s_in   = (scale == '0) ? SCALE_W'(1) : scale;
    assign x1_ext = EXT_W'(origin_x) + EXT_W'(WIDTH) * EXT_W'(s_in) - EXT_W'(1);
    assign y1_ext = EXT_W'(origin_y) + EXT_W'(HEIGHT) * EXT_W'(s_in) - EXT_W'(1);
    assign reject = (x1_ext >= EXT_W'(PANEL_W)) || (y1_ext >= EXT_W'(PANEL_H));
    assign accept_start = (state_q == ST_IDLE) && start;

    // A read may only issue if FIFO plus the in-flight word still leaves a free slot.
    assign pop       = lcd.rect_pixel_write_valid && lcd.rect_pixel_write_ready;
    assign occupancy = 3'(fifo_count) + 3'(pend_q) - 3'(pop);
    assign issue     = (state_q == ST_STREAM) && !reads_done_q && (occupancy < 3'd2);

    assign last_read = (sx_q == smax_q) && (ax_q == WIDTH_W'(WIDTH - 1)) &&
                       (sy_q == smax_q) && (ay_q == HEIGHT_W'(HEIGHT - 1));
    assign last_accept = (state_q == ST_STREAM) && pop && reads_done_q && !pend_q &&
                         (fifo_count == 2'd1);

    always_comb begin
        state_d     = state_q;
        lcd.command = LCD_COMMAND_NONE;
        case (state_q)
            ST_IDLE:   if (start && !reject) state_d = ST_CMD;
            ST_CMD: begin
                if (lcd.lcd_ready) begin
                    lcd.command = LCD_COMMAND_WRITE_RECT;
                    state_d     = ST_STREAM;
                end
            end
            ST_STREAM: if (last_accept) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rej_q        <= 1'b0;
            pend_q       <= 1'b0;
            reads_done_q <= 1'b0;
            x0_q         <= '0;
            x1_q         <= '0;
            y0_q         <= '0;
            y1_q         <= '0;
            smax_q       <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            ax_q         <= '0;
            ay_q         <= '0;
        end else begin
            state_q <= state_d;
            rej_q   <= accept_start && reject;
            pend_q  <= issue;
            if (accept_start && !reject) begin
                x0_q         <= origin_x;
                y0_q         <= origin_y;
                x1_q         <= x1_ext[COORD_W-1:0];
                y1_q         <= y1_ext[COORD_W-1:0];
                smax_q       <= s_in - SCALE_W'(1);
                sx_q         <= '0;
                sy_q         <= '0;
                ax_q         <= '0;
                ay_q         <= '0;
                reads_done_q <= 1'b0;
            end else if (issue) begin
                // Replication counters: sub_x innermost, then image x, sub_y, image y.
                if (last_read) reads_done_q <= 1'b1;
                if (sx_q != smax_q) begin
                    sx_q <= sx_q + SCALE_W'(1);
                end else begin
                    sx_q <= '0;
                    if (ax_q != WIDTH_W'(WIDTH - 1)) begin
                        ax_q <= ax_q + WIDTH_W'(1);
                    end else begin
                        ax_q <= '0;
                        if (sy_q != smax_q) begin
                            sy_q <= sy_q + SCALE_W'(1);
                        end else begin
                            sy_q <= '0;
                            ay_q <= (ay_q == HEIGHT_W'(HEIGHT - 1)) ? '0 : ay_q + HEIGHT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign pixel_in = rgb888_to_565(buffer_out_data);

    image_lcd_pixel_fifo u_fifo (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (pend_q),
        .in_data_i   (pixel_in),
        .out_ready_i (lcd.rect_pixel_write_ready),
        .out_valid_o (lcd.rect_pixel_write_valid),
        .out_data_o  (lcd.rect_pixel_write),
        .count_o     (fifo_count)
    );

    assign lcd.rect_x0   = x0_q;
    assign lcd.rect_x1   = x1_q;
    assign lcd.rect_y0   = y0_q;
    assign lcd.rect_y1   = y1_q;
    assign buffer_out_x  = ax_q;
    assign buffer_out_y  = ay_q;
    assign busy          = (state_q == ST_CMD) || (state_q == ST_STREAM);
    assign done          = (state_q == ST_DONE) || rej_q;
    assign error         = rej_q;

endmodule

// File: tb/tb_image_lcd_blit.sv
// Directed bench for image_lcd_blit: image pixel(x,y) = {x*16, y*16, 0}, so RGB565 = (2x)<<11 | (4y)<<5.
module tb_image_lcd_blit;
    import image_lcd_blit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  origin_x = '0;
    logic [8:0]  origin_y = '0;
    logic [2:0]  scale = 3'd1;
    logic        busy, done, error;
    logic [3:0]  bx, by;
    logic [23:0] bdata = '0;

    image_lcd_blit_if lcd_if ();

    image_lcd_blit dut (
        .clock           (clk),
        .reset           (rst_n),
        .start           (start),
        .origin_x        (origin_x),
        .origin_y        (origin_y),
        .scale           (scale),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .buffer_out_x    (bx),
        .buffer_out_y    (by),
        .buffer_out_data (bdata),
        .lcd             (lcd_if)
    );

    always #5 clk = ~clk;

    // Image buffer model: synchronous read, data one cycle after address.
    always @(posedge clk) bdata <= {bx, 4'h0, by, 4'h0, 8'h00};

    int checks = 0;
    int failures = 0;

    logic [15:0] got[$];
    int wr_cyc, first_v, last_acc, done_cyc, cmd_cnt, err_cnt, viol;
    logic busy_seen, timed_out, done_busy, done_valid;
    logic [8:0] rx0, rx1, ry0, ry1;
    int bad_idx;
    logic [15:0] bad_got, bad_exp;

    function automatic int seq_errors(input int s);
        int n = 0;
        for (int k = 0; k < got.size(); k++) begin
            int px = k % (10 * s);
            int py = k / (10 * s);
            logic [15:0] e = 16'(((px / s) * 2) << 11) | 16'(((py / s) * 4) << 5);
            if (got[k] !== e) begin
                if (n == 0) begin bad_idx = k; bad_got = got[k]; bad_exp = e; end
                n++;
            end
        end
        return n;
    endfunction

    task automatic blit(input logic [8:0] ox, input logic [8:0] oy, input logic [2:0] sc,
                        input int duty, input int rdy_delay, input int start2_at,
                        input int abort_at);
        logic prev_hold = 1'b0;
        logic [15:0] prev_pix = '0;
        got.delete();
        wr_cyc = -1; first_v = -1; last_acc = -1; done_cyc = -1;
        cmd_cnt = 0; err_cnt = 0; viol = 0;
        busy_seen = 1'b0; timed_out = 1'b0; done_busy = 1'b0; done_valid = 1'b0;
        @(negedge clk);
        origin_x = ox; origin_y = oy; scale = sc; start = 1'b1;
        lcd_if.lcd_ready = (rdy_delay == 0);
        for (int i = 1; i <= 6000; i++) begin
            @(negedge clk);
            start = (i == start2_at);
            lcd_if.lcd_ready = (i > rdy_delay);
            lcd_if.rect_pixel_write_ready = ($urandom_range(99) < duty);
            #1;
            if (abort_at > 0 && got.size() == abort_at) begin
                rst_n = 1'b0;
                #1;
                return;
            end
            if (busy) busy_seen = 1'b1;
            if (error) err_cnt++;
            if (lcd_if.command !== LCD_COMMAND_NONE) begin
                cmd_cnt++;
                if (lcd_if.command === LCD_COMMAND_WRITE_RECT) begin
                    wr_cyc = i;
                    rx0 = lcd_if.rect_x0; rx1 = lcd_if.rect_x1;
                    ry0 = lcd_if.rect_y0; ry1 = lcd_if.rect_y1;
                end
            end
            if (lcd_if.rect_pixel_write_valid) begin
                if (first_v < 0) first_v = i;
                if (prev_hold && lcd_if.rect_pixel_write !== prev_pix) viol++;
            end else if (prev_hold) begin
                viol++;
            end
            if (lcd_if.rect_pixel_write_valid && lcd_if.rect_pixel_write_ready) begin
                got.push_back(lcd_if.rect_pixel_write);
                last_acc = i;
            end
            prev_hold = lcd_if.rect_pixel_write_valid && !lcd_if.rect_pixel_write_ready;
            prev_pix  = lcd_if.rect_pixel_write;
            if (done) begin
                done_cyc = i; done_busy = busy; done_valid = lcd_if.rect_pixel_write_valid;
                return;
            end
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        checks++;
        if ({busy, done, error, lcd_if.rect_pixel_write_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {busy, done, error, lcd_if.rect_pixel_write_valid});
        end
        checks++;
        if (lcd_if.command !== LCD_COMMAND_NONE || {bx, by} !== 8'h00 ||
            {lcd_if.rect_x0, lcd_if.rect_x1, lcd_if.rect_y0, lcd_if.rect_y1} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs cmd=%0d addr=%h x1=%0d exp cmd=0 addr=00 rect=0",
                     lcd_if.command, {bx, by}, lcd_if.rect_x1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scale1();
        int n;
        blit(9'd0, 9'd0, 3'd1, 100, 0, 0, 0);
        checks++;
        if (timed_out !== 1'b0) begin failures++; $display("FAIL t1_timeout got=1 exp=0"); end
        checks++;
        if (got.size() !== 100) begin failures++; $display("FAIL t1_count got=%0d exp=100", got.size()); end
        n = seq_errors(1);
        checks++;
        if (n !== 0) begin failures++;
            $display("FAIL t1_sequence bad=%0d idx=%0d got=%h exp=%h", n, bad_idx, bad_got, bad_exp); end
        checks++;
        if (got.size() == 100 && (got[0] !== 16'h0000 || got[99] !== 16'h9480)) begin failures++;
            $display("FAIL t1_corners got=%h,%h exp=0000,9480", got[0], got[99]); end
        checks++;
        if ({rx0, rx1, ry0, ry1} !== {9'd0, 9'd9, 9'd0, 9'd9}) begin failures++;
            $display("FAIL t1_rect got=%0d..%0d/%0d..%0d exp=0..9/0..9", rx0, rx1, ry0, ry1); end
        checks++;
        if (cmd_cnt !== 1 || wr_cyc !== 1) begin failures++;
            $display("FAIL t1_command got cnt=%0d cyc=%0d exp cnt=1 cyc=1", cmd_cnt, wr_cyc); end
        checks++;
        if (first_v - wr_cyc < 2) begin failures++;
            $display("FAIL t1_first_latency got=%0d exp>=2", first_v - wr_cyc); end
        checks++;
        if (last_acc - first_v !== 99) begin failures++;
            $display("FAIL t1_throughput got=%0d exp=99", last_acc - first_v); end
        checks++;
        if (done_cyc !== last_acc + 1 || done_busy !== 1'b0 || done_valid !== 1'b0 || err_cnt !== 0) begin
            failures++;
            $display("FAIL t1_done got cyc=%0d busy=%b valid=%b err=%0d exp cyc=%0d busy=0 valid=0 err=0",
                     done_cyc, done_busy, done_valid, err_cnt, last_acc + 1);
        end
    endtask

    task automatic test_back_to_back_idle();
        int extra = 0;
        lcd_if.rect_pixel_write_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (busy || done || lcd_if.rect_pixel_write_valid || lcd_if.command !== LCD_COMMAND_NONE) extra++;
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL idle_after_done got=%0d exp=0", extra); end
    endtask

    task automatic test_scale3();
        int n;
        blit(9'd100, 9'd50, 3'd3, 100, 0, 0, 0);
        checks++;
        if (got.size() !== 900 || timed_out) begin failures++;
            $display("FAIL t2_count got=%0d exp=900", got.size()); end
        n = seq_errors(3);
        checks++;
        if (n !== 0) begin failures++;
            $display("FAIL t2_sequence bad=%0d idx=%0d got=%h exp=%h", n, bad_idx, bad_got, bad_exp); end
        checks++;
        if (got.size() == 900 && (got[93] !== 16'h1080 || got[899] !== 16'h9480)) begin failures++;
            $display("FAIL t2_spot got=%h,%h exp=1080,9480", got[93], got[899]); end
        checks++;
        if ({rx0, rx1, ry0, ry1} !== {9'd100, 9'd129, 9'd50, 9'd79}) begin failures++;
            $display("FAIL t2_rect got=%0d..%0d/%0d..%0d exp=100..129/50..79", rx0, rx1, ry0, ry1); end
    endtask

    task automatic test_backpressure();
        int n;
        blit(9'd20, 9'd30, 3'd2, 40, 0, 0, 0);
        checks++;
        if (got.size() !== 400 || timed_out) begin failures++;
            $display("FAIL t3_count got=%0d exp=400", got.size()); end
        n = seq_errors(2);
        checks++;
        if (n !== 0) begin failures++;
            $display("FAIL t3_sequence bad=%0d idx=%0d got=%h exp=%h", n, bad_idx, bad_got, bad_exp); end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL t3_stable got=%0d exp=0", viol); end
    endtask

    task automatic test_reject();
        blit(9'd475, 9'd0, 3'd1, 100, 0, 0, 0);
        checks++;
        if (done_cyc !== 1 || err_cnt !== 1 || busy_seen !== 1'b0 || cmd_cnt !== 0 || got.size() !== 0) begin
            failures++;
            $display("FAIL t4_reject_x got done=%0d err=%0d busy=%b cmd=%0d px=%0d exp 1,1,0,0,0",
                     done_cyc, err_cnt, busy_seen, cmd_cnt, got.size());
        end
        @(negedge clk); #1;
        checks++;
        if ({done, error, busy} !== 3'b000) begin failures++;
            $display("FAIL t4_pulse got=%b exp=000", {done, error, busy}); end
        blit(9'd0, 9'd311, 3'd1, 100, 0, 0, 0);
        checks++;
        if (done_cyc !== 1 || err_cnt !== 1 || busy_seen !== 1'b0) begin failures++;
            $display("FAIL t4_reject_y got done=%0d err=%0d busy=%b exp 1,1,0", done_cyc, err_cnt, busy_seen); end
        blit(9'd470, 9'd310, 3'd1, 100, 0, 0, 0);
        checks++;
        if (err_cnt !== 0 || got.size() !== 100 || rx1 !== 9'd479 || ry1 !== 9'd319) begin failures++;
            $display("FAIL t4_edge_fit got err=%0d px=%0d x1=%0d y1=%0d exp 0,100,479,319",
                     err_cnt, got.size(), rx1, ry1); end
        blit(9'd0, 9'd0, 3'd0, 100, 0, 0, 0);
        checks++;
        if (got.size() !== 100 || rx1 !== 9'd9 || ry1 !== 9'd9 || seq_errors(1) !== 0) begin failures++;
            $display("FAIL t4_scale0 got px=%0d x1=%0d y1=%0d exp 100,9,9", got.size(), rx1, ry1); end
    endtask

    task automatic test_lcd_wait();
        blit(9'd0, 9'd0, 3'd1, 100, 50, 70, 0);
        checks++;
        if (wr_cyc !== 51 || cmd_cnt !== 1 || busy_seen !== 1'b1) begin failures++;
            $display("FAIL t5_wait got wr=%0d cmd=%0d busy=%b exp 51,1,1", wr_cyc, cmd_cnt, busy_seen); end
        checks++;
        if (got.size() !== 100 || seq_errors(1) !== 0) begin failures++;
            $display("FAIL t5_stream got px=%0d exp=100", got.size()); end
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL t5_second_start got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_abort();
        blit(9'd10, 9'd20, 3'd1, 100, 0, 0, 37);
        checks++;
        if (got.size() !== 37 || rst_n !== 1'b0) begin failures++;
            $display("FAIL t6_reach got px=%0d exp=37", got.size()); end
        checks++;
        if ({busy, done, error, lcd_if.rect_pixel_write_valid} !== 4'b0000 ||
            lcd_if.command !== LCD_COMMAND_NONE || {bx, by} !== 8'h00 ||
            {lcd_if.rect_x0, lcd_if.rect_x1, lcd_if.rect_y0, lcd_if.rect_y1} !== 36'h0) begin
            failures++;
            $display("FAIL t6_async_reset got flags=%b cmd=%0d addr=%h x1=%0d exp 0000,0,00,0",
                     {busy, done, error, lcd_if.rect_pixel_write_valid}, lcd_if.command, {bx, by},
                     lcd_if.rect_x1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        blit(9'd0, 9'd0, 3'd1, 100, 0, 0, 0);
        checks++;
        if (got.size() !== 100 || seq_errors(1) !== 0 || done_cyc !== last_acc + 1) begin failures++;
            $display("FAIL t6_restart got px=%0d done=%0d exp 100,%0d", got.size(), done_cyc, last_acc + 1); end
    endtask

    initial begin
        lcd_if.lcd_ready = 1'b0;
        lcd_if.rect_pixel_write_ready = 1'b0;
        test_reset();
        test_scale1();
        test_back_to_back_idle();
        test_scale3();
        test_backpressure();
        test_reject();
        test_lcd_wait();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
